// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
// Optional readback of displaced chain content: CCFF_READBACK_EN.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WORD_W    = 32;
   localparam int DEF_CHAIN_LEN = 64;

   function automatic int last_word_bits(
      input int chain_len,
      input int word_w
   );
      int rem;
      rem = chain_len % word_w;
      return (rem == 0) ? word_w : rem;
   endfunction

   function automatic int words_per_chain(
      input int chain_len,
      input int word_w
   );
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-wide shift register emitting its pending bits MSB-first.
// A load replaces content and overrides a same-cycle shift.
module ccff_word_serializer
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   localparam int SB_W = $clog2(WORD_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic [WORD_W-1:0] data,
   input  logic [SB_W-1:0]   load_bits,
   input  logic              shift,
   output logic              head,
   output logic [SB_W-1:0]   sh_bits
);

   logic [WORD_W-1:0] sh_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_reg  <= '0;
         sh_bits <= '0;
      end else if (clear) begin
         sh_reg  <= '0;
         sh_bits <= '0;
      end else if (load) begin
         sh_reg  <= data;
         sh_bits <= load_bits;
      end else if (shift) begin
         sh_reg  <= {sh_reg[WORD_W-2:0], 1'b0};
         sh_bits <= sh_bits - 1'b1;
      end
   end

   assign head = (sh_bits != '0) & sh_reg[WORD_W-1];

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams configuration words MSB-first into a tile's ccff chain.
// Define CCFF_READBACK_EN to capture the displaced chain content.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W    = DEF_WORD_W,
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_clk_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bit_cnt
`ifdef CCFF_READBACK_EN
   ,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
`endif
);

   localparam int SB_W      = $clog2(WORD_W + 1);
   localparam int WORDS     = words_per_chain(CHAIN_LEN, WORD_W);
   localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
   localparam int WC_W      = $clog2(WORDS + 1);

   state_t           state;
   state_t           state_nx;
   logic [SB_W-1:0]  sh_bits;
   logic [SB_W-1:0]  load_bits;
   logic [WC_W-1:0]  word_cnt;
   logic             accept;
   logic             go;
   logic             last_shift;

   // Load may land in the same cycle the last pending bit leaves.
   assign ccff_clk_en = (state == LOAD) && (sh_bits != '0);
   assign cfg_ready   = (state == LOAD)
                     && ((sh_bits == '0)
                      || ((sh_bits == SB_W'(1)) && ccff_clk_en))
                     && (word_cnt < WC_W'(WORDS));
   assign accept      = cfg_valid && cfg_ready;
   assign go          = start && !abort
                     && ((state == IDLE) || (state == DONE));
   assign last_shift  = ccff_clk_en
                     && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
   assign load_bits   = (word_cnt == WC_W'(WORDS - 1))
                     ? SB_W'(LAST_BITS) : SB_W'(WORD_W);
   assign busy        = (state == LOAD);
   assign done        = (state == DONE);

   ccff_word_serializer #(
      .WORD_W(WORD_W)
   ) u_ser (
      .clk      (prog_clk),
      .rst_n    (prog_reset_n),
      .clear    (abort || go),
      .load     (accept),
      .data     (cfg_data),
      .load_bits(load_bits),
      .shift    (ccff_clk_en),
      .head     (ccff_head),
      .sh_bits  (sh_bits)
   );

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (last_shift) state_nx = DONE;
            DONE:    if (start) state_nx = LOAD;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         bit_cnt  <= '0;
         word_cnt <= '0;
      end else if (go) begin
         bit_cnt  <= '0;
         word_cnt <= '0;
      end else begin
         if (ccff_clk_en) bit_cnt <= bit_cnt + 1'b1;
         if (accept) word_cnt <= word_cnt + 1'b1;
      end
   end

`ifdef CCFF_READBACK_EN
   logic [WORD_W-2:0] rb_sh;
   logic [SB_W-1:0]   rb_cnt;
   logic [WORD_W-1:0] rb_word;
   logic [SB_W-1:0]   rb_cnt_nx;

   assign rb_word   = {rb_sh, ccff_tail};
   assign rb_cnt_nx = rb_cnt + 1'b1;

   // Partial final word is left-aligned, zero-padded.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         rb_sh    <= '0;
         rb_cnt   <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (abort || go) begin
            rb_sh  <= '0;
            rb_cnt <= '0;
         end else if (ccff_clk_en) begin
            if ((rb_cnt_nx == SB_W'(WORD_W)) || last_shift) begin
               rb_data  <= rb_word << (SB_W'(WORD_W) - rb_cnt_nx);
               rb_valid <= 1'b1;
               rb_sh    <= '0;
               rb_cnt   <= '0;
            end else begin
               rb_sh  <= rb_word[WORD_W-2:0];
               rb_cnt <= rb_cnt_nx;
            end
         end
      end
   end
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

endmodule
